// File: rtl/rx_buffer_reader.sv
// rx_buffer_reader: read-side sequencer for the 512 x 64-bit Ethernet receive ring
// Ports: clk, reset_n (async, active-low); enable gates the start of new frames;
//   commited_wr_address is the writer's next-header pointer; rd_addr/rd_data form
//   the ring read port (1-cycle latency); rd_addr_extended returns freed space;
//   out_* is the valid/ready frame stream; frames_read and ring_error are status.
module rx_buffer_reader #(
  parameter int MAX_BYTES = 4088
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [9:0]  commited_wr_address,
  output logic [8:0]  rd_addr,
  input  logic [63:0] rd_data,
  output logic [9:0]  rd_addr_extended,
  output logic [63:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sof,
  output logic        out_eof,
  output logic [15:0] out_len,
  output logic [3:0]  out_last_bytes,
  output logic [31:0] frames_read,
  output logic        ring_error
);
  typedef enum logic [1:0] {IDLE, HDR, DATA, RELEASE} state_t;
  state_t r_state, w_next;
  logic [9:0] r_hdr_ptr, r_data_ptr, r_words_left, r_next_ptr, r_rd_ext;
  logic [15:0] r_len;
  logic [31:0] r_frames;
  logic r_err, r_p, r_p_sof, r_p_eof;
  logic [65:0] r_s0, r_s1;
  logic [1:0] r_cnt;
  logic [31:0] w_bc;
  logic [9:0] w_nwords, w_hdr_inc;
  logic w_bad, w_zero, w_empty, w_valid, w_pop, w_room, w_issue;
  logic [65:0] w_in, w_head;
  assign w_bc = rd_data[63:32];
  assign w_bad = w_bc > 32'(MAX_BYTES);
  assign w_zero = w_bc == 32'd0;
  assign w_nwords = w_bc[12:3] + {9'd0, |w_bc[2:0]};
  assign w_hdr_inc = r_hdr_ptr + 10'd1;
  assign w_empty = r_hdr_ptr == commited_wr_address;
  // The header cycle speculatively reads the first data word; it is only
  // tagged as pending when the header turns out to describe a real frame.
  assign rd_addr = (r_state == DATA) ? r_data_ptr[8:0] : (r_state == HDR) ? w_hdr_inc[8:0] : r_hdr_ptr[8:0];
  // Word arriving from the ring bypasses the skid buffer when it is empty.
  assign w_in = {r_p_sof, r_p_eof, rd_data};
  assign w_head = (r_cnt != 2'd0) ? r_s0 : w_in;
  assign w_valid = (r_cnt != 2'd0) || r_p;
  assign w_pop = w_valid && out_ready;
  // A new read lands next cycle; buffered plus in-flight words after this
  // edge must leave one free slot for it even if the consumer then stalls.
  assign w_room = ({1'b0, r_cnt} + {2'd0, r_p}) <= ({2'd0, w_pop} + 3'd1);
  assign w_issue = (r_state == DATA) && (r_words_left != 10'd0) && w_room;
  assign out_data = w_head[63:0];
  assign out_valid = w_valid;
  assign out_sof = w_valid && w_head[65];
  assign out_eof = w_valid && w_head[64];
  assign out_len = r_len;
  assign out_last_bytes = (r_len[2:0] != 3'd0) ? {1'b0, r_len[2:0]} : 4'd8;
  assign rd_addr_extended = r_rd_ext;
  assign frames_read = r_frames;
  assign ring_error = r_err;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (enable && !w_empty) ? HDR : IDLE;
      HDR:     w_next = w_bad ? IDLE : w_zero ? RELEASE : DATA;
      DATA:    w_next = (w_pop && w_head[64]) ? RELEASE : DATA;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hdr_ptr <= '0;
      r_data_ptr <= '0;
      r_words_left <= '0;
      r_next_ptr <= '0;
      r_rd_ext <= '0;
      r_len <= '0;
      r_frames <= '0;
      r_err <= 1'b0;
      r_p <= 1'b0;
      r_p_sof <= 1'b0;
      r_p_eof <= 1'b0;
      r_s0 <= '0;
      r_s1 <= '0;
      r_cnt <= '0;
    end else begin
      r_p <= w_issue || (r_state == HDR && !w_bad && !w_zero);
      r_p_sof <= r_state == HDR;
      r_p_eof <= (r_state == HDR) ? (w_nwords == 10'd1) : (r_words_left == 10'd1);
      if (r_state == HDR) begin
        r_len <= w_bc[15:0];
        r_data_ptr <= r_hdr_ptr + 10'd2;
        r_words_left <= w_nwords - 10'd1;
        r_next_ptr <= w_hdr_inc + w_nwords;
        if (w_bad) begin
          r_err <= 1'b1;
          r_hdr_ptr <= commited_wr_address;
          r_rd_ext <= commited_wr_address;
        end
      end
      if (w_issue) begin
        r_data_ptr <= r_data_ptr + 10'd1;
        r_words_left <= r_words_left - 10'd1;
      end
      if (r_state == RELEASE) begin
        r_hdr_ptr <= r_next_ptr;
        r_rd_ext <= r_next_ptr;
        r_frames <= r_frames + {31'd0, r_len != 16'd0};
      end
      // Two-entry skid FIFO: r_s0 is the head, r_s1 the tail.
      if (r_cnt == 2'd0) begin
        if (r_p && !w_pop) r_s0 <= w_in;
      end else if (r_cnt == 2'd1) begin
        if (w_pop) r_s0 <= w_in;
        else r_s1 <= w_in;
      end else if (w_pop) begin
        r_s0 <= r_s1;
        r_s1 <= w_in;
      end
      r_cnt <= r_cnt + {1'b0, r_p} - {1'b0, w_pop};
    end
  end
endmodule

// File: tb/tb_rx_buffer_reader.sv
// tb_rx_buffer_reader: self-checking bench for rx_buffer_reader
module tb_rx_buffer_reader;
  localparam int MAXB = 4088;
  typedef struct packed {
    logic [63:0] d;
    logic        sof;
    logic        eof;
    logic [15:0] len;
    logic [3:0]  lb;
  } beat_t;
  typedef struct {
    int bc;
    int beats;
    int lb;
    int adv;
  } vec_t;
  logic clk = 0, reset_n = 0, enable = 1, out_ready = 1;
  logic [9:0] commited_wr_address = '0;
  logic [8:0] rd_addr;
  logic [63:0] rd_data;
  logic [9:0] rd_addr_extended;
  logic [63:0] out_data;
  logic out_valid, out_sof, out_eof, ring_error;
  logic [15:0] out_len;
  logic [3:0] out_last_bytes;
  logic [31:0] frames_read;
  logic [63:0] ring [512];
  beat_t exp_q[$], got_q[$];
  int gotc_q[$], addr_q[$];
  int total = 0, bad = 0, wp = 0, frames_exp = 0, cyc = 0, vcount = 0, mode = 0, nbeats = 0, last_lb = 0, k = 0;
  bit rec = 0, stall_p = 0;
  beat_t held, cur;
  logic [3:0] pat = 4'b1001;
  rx_buffer_reader #(.MAX_BYTES(MAXB)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .commited_wr_address(commited_wr_address),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_addr_extended(rd_addr_extended),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_eof(out_eof), .out_len(out_len),
    .out_last_bytes(out_last_bytes), .frames_read(frames_read), .ring_error(ring_error)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    rd_data <= ring[rd_addr];
    cyc <= cyc + 1;
  end
  initial begin
    forever begin
      @(posedge clk);
      #1;
      k++;
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? pat[k % 4] : 1'($urandom_range(0, 1));
    end
  end
  always @(negedge clk) begin
    if (!reset_n) stall_p = 0;
    else begin
      cur = {out_data, out_sof, out_eof, out_len, out_last_bytes};
      if (stall_p) begin
        total++;
        if (!out_valid || cur !== held) begin
          bad++;
          $display("FAIL stall_hold: got valid=%0b beat=%0h want valid=1 beat=%0h", out_valid, cur, held);
        end
      end
      if (out_valid) vcount++;
      if (out_valid && out_ready) begin
        got_q.push_back(cur);
        gotc_q.push_back(cyc);
      end
      stall_p = out_valid && !out_ready;
      held = cur;
      if (rec && (addr_q.size() == 0 || addr_q[$] != int'(rd_addr))) addr_q.push_back(int'(rd_addr));
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic write_frame(input int bc);
    int n;
    beat_t b;
    logic [63:0] d;
    n = (bc > MAXB) ? 0 : (bc + 7) / 8;
    ring[wp % 512] = {32'(bc), 32'($urandom)};
    for (int i = 0; i < n; i++) begin
      d = {32'($urandom), 32'($urandom)};
      ring[(wp + 1 + i) % 512] = d;
      b.d = d;
      b.sof = (i == 0);
      b.eof = (i == n - 1);
      b.len = 16'(bc);
      b.lb = (bc % 8 == 0) ? 4'd8 : 4'(bc % 8);
      exp_q.push_back(b);
    end
    if (n > 0) frames_exp++;
    wp = (wp + 1 + n) % 1024;
  endtask
  task automatic drain(input bit timing);
    int n = 0, gc = 0, pc = 0;
    beat_t g, e;
    while ((rd_addr_extended != commited_wr_address || got_q.size() < exp_q.size()) && n < 8000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_done", 128'(n < 8000), 128'd1);
    check("beat_count", 128'(got_q.size()), 128'(exp_q.size()));
    nbeats = got_q.size();
    last_lb = 0;
    for (int i = 0; i < nbeats && exp_q.size() > 0; i++) begin
      g = got_q.pop_front();
      gc = gotc_q.pop_front();
      e = exp_q.pop_front();
      check("beat", 128'(g), 128'(e));
      if (timing && i > 0) check("beat_gap", 128'(gc - pc), e.sof ? 128'd4 : 128'd1);
      pc = gc;
      last_lb = int'(g.lb);
    end
    got_q.delete();
    gotc_q.delete();
    exp_q.delete();
  endtask
  task automatic wait_beats(input int cnt);
    int n = 0;
    while (got_q.size() < cnt && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wait_beats", 128'(n < 2000), 128'd1);
  endtask
  task automatic do_reset();
    reset_n = 0;
    commited_wr_address = '0;
    wp = 0;
    frames_exp = 0;
    exp_q.delete();
    got_q.delete();
    gotc_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
  endtask
  initial begin
    vec_t tbl[9];
    int wexp[6];
    int eptr;
    tbl[0] = '{1, 1, 1, 2};
    tbl[1] = '{8, 1, 8, 2};
    tbl[2] = '{9, 2, 1, 3};
    tbl[3] = '{60, 8, 4, 9};
    tbl[4] = '{64, 8, 8, 9};
    tbl[5] = '{0, 0, 0, 1};
    tbl[6] = '{15, 2, 7, 3};
    tbl[7] = '{4088, 511, 8, 512};
    tbl[8] = '{4089, 0, 0, 1};
    wexp = '{508, 509, 510, 511, 0, 1};
    for (int i = 0; i < 512; i++) ring[i] = '0;
    #1;
    check("rst_rd_addr", 128'(rd_addr), 128'd0);
    check("rst_rd_ext", 128'(rd_addr_extended), 128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_sof_eof", 128'({out_sof, out_eof}), 128'd0);
    check("rst_out_len", 128'(out_len), 128'd0);
    check("rst_frames", 128'(frames_read), 128'd0);
    check("rst_ring_error", 128'(ring_error), 128'd0);
    do_reset();
    // single frame
    write_frame(60);
    commited_wr_address = 10'(wp);
    drain(1);
    check("single_last_bytes", 128'(last_lb), 128'd4);
    check("single_rd_ext", 128'(rd_addr_extended), 128'd9);
    check("single_frames", 128'(frames_read), 128'd1);
    // backpressure
    do_reset();
    mode = 1;
    write_frame(64);
    commited_wr_address = 10'(wp);
    drain(0);
    check("bp_beats", 128'(nbeats), 128'd8);
    check("bp_last_bytes", 128'(last_lb), 128'd8);
    mode = 0;
    // back-to-back
    do_reset();
    for (int i = 0; i < 3; i++) write_frame(64);
    commited_wr_address = 10'(wp);
    drain(1);
    check("b2b_beats", 128'(nbeats), 128'd24);
    check("b2b_frames", 128'(frames_read), 128'd3);
    check("b2b_rd_ext", 128'(rd_addr_extended), 128'd27);
    // corrupt header
    do_reset();
    ring[0] = {32'd5000, 32'h0};
    vcount = 0;
    commited_wr_address = 10'd100;
    wp = 100;
    drain(0);
    check("bad_ring_error", 128'(ring_error), 128'd1);
    check("bad_no_valid", 128'(vcount), 128'd0);
    check("bad_rd_ext", 128'(rd_addr_extended), 128'd100);
    check("bad_frames", 128'(frames_read), 128'd0);
    // wrap-around
    do_reset();
    write_frame(4056);
    commited_wr_address = 10'(wp);
    drain(1);
    check("wrap_fill_ptr", 128'(rd_addr_extended), 128'd508);
    addr_q.delete();
    rec = 1;
    write_frame(40);
    commited_wr_address = 10'(wp);
    drain(1);
    rec = 0;
    check("wrap_rd_ext", 128'(rd_addr_extended), 128'd514);
    check("wrap_addr_count", 128'(addr_q.size() >= 6), 128'd1);
    for (int i = 0; i < 6 && i < addr_q.size(); i++) check("wrap_rd_addr", 128'(addr_q[i]), 128'(wexp[i]));
    // enable gating, mid-frame enable drop, mid-frame reset
    do_reset();
    enable = 0;
    write_frame(24);
    commited_wr_address = 10'(wp);
    addr_q.delete();
    vcount = 0;
    rec = 1;
    repeat (20) @(posedge clk);
    #1;
    rec = 0;
    check("en0_no_reads", 128'(addr_q.size()), 128'd1);
    check("en0_no_valid", 128'(vcount), 128'd0);
    check("en0_rd_ext", 128'(rd_addr_extended), 128'd0);
    enable = 1;
    drain(1);
    check("en1_frames", 128'(frames_read), 128'd1);
    check("en1_rd_ext", 128'(rd_addr_extended), 128'd4);
    mode = 1;
    write_frame(200);
    commited_wr_address = 10'(wp);
    wait_beats(2);
    enable = 0;
    drain(0);
    check("endrop_frames", 128'(frames_read), 128'd2);
    check("endrop_rd_ext", 128'(rd_addr_extended), 128'(wp));
    enable = 1;
    mode = 0;
    write_frame(800);
    commited_wr_address = 10'(wp);
    wait_beats(5);
    reset_n = 0;
    #1;
    check("midrst_valid", 128'(out_valid), 128'd0);
    check("midrst_sof_eof", 128'({out_sof, out_eof}), 128'd0);
    check("midrst_len", 128'(out_len), 128'd0);
    check("midrst_rd_addr", 128'(rd_addr), 128'd0);
    check("midrst_rd_ext", 128'(rd_addr_extended), 128'd0);
    check("midrst_frames", 128'(frames_read), 128'd0);
    // table-driven lengths
    do_reset();
    mode = 2;
    eptr = 0;
    for (int i = 0; i < 9; i++) begin
      write_frame(tbl[i].bc);
      commited_wr_address = 10'(wp);
      drain(0);
      eptr = (eptr + tbl[i].adv) % 1024;
      check("tbl_beats", 128'(nbeats), 128'(tbl[i].beats));
      if (tbl[i].beats > 0) check("tbl_last_bytes", 128'(last_lb), 128'(tbl[i].lb));
      check("tbl_rd_ext", 128'(rd_addr_extended), 128'(eptr));
      check("tbl_frames", 128'(frames_read), 128'(frames_exp));
    end
    check("tbl_ring_error", 128'(ring_error), 128'd1);
    // randomized batches
    for (int b = 0; b < 40; b++) begin
      int nf;
      nf = $urandom_range(1, 4);
      for (int f = 0; f < nf; f++) write_frame(($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 600)));
      commited_wr_address = 10'(wp);
      drain(0);
      check("rand_rd_ext", 128'(rd_addr_extended), 128'(wp));
      check("rand_frames", 128'(frames_read), 128'(frames_exp));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
